sr_responder: RTL and testbench
===============================

# sr_responder

Cycle-accurate, synthesizable model of the chip-side configuration shift register. It sits at the far end of the serial link driven by the shift-register read/write controller: it accepts the serial clock, data and load strobes and returns serial data, all oversampled on one system clock. It is used in loopback firmware builds and as the DUT-side partner in controller benches. A readback frame returns the register contents shifted in by the previous frame.

## Interface
Parameters:
- WIDTH, 170, shift/shadow register length in bits
- CNT_WIDTH, 8, width of the bit counter; must satisfy 2^CNT_WIDTH > WIDTH
- SHIFT_DIRECTION, 1, 1: data enters at bit 0 and leaves at bit WIDTH-1; 0: data enters at bit WIDTH-1 and leaves at bit 0
- SYNC_STAGES, 2, synchronizer depth on sr_clk, sr_din and sr_load (minimum 2)

Ports:
- clk_in  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- sr_clk  in  1  serial shift clock from the controller, asynchronous
- sr_din  in  1  serial data from the controller, asynchronous
- sr_load  in  1  load strobe from the controller, asynchronous
- preset_en  in  1  one-cycle pulse: copy preset_data into the shift register
- preset_data  in  WIDTH  value injected by preset_en
- sr_dout  out  1  serial data returned to the controller
- shadow  out  WIDTH  configuration register, updated on load
- load_done  out  1  one-cycle pulse when shadow updates
- frame_err  out  1  sticky; set when a load arrives with bit_cnt != WIDTH
- bit_cnt  out  CNT_WIDTH  number of sr_clk rising edges since the last load, saturating

## Operation
- All three serial inputs pass through SYNC_STAGES flip-flops plus one edge-detect register.
- rise_clk = sync_clk & ~sync_clk_d; rise_load = sync_load & ~sync_load_d.
- FSM states:
  - IDLE: no shift since the last load or reset.
  - SHIFT: at least one rise_clk has been seen.
  - LATCH: one cycle; shadow <= sreg, load_done = 1, bit_cnt <= 0; then IDLE.
- Transitions:
  - IDLE to SHIFT on rise_clk.
  - SHIFT or IDLE to LATCH on rise_load.
- On rise_clk with SHIFT_DIRECTION = 1: sreg <= {sreg[WIDTH-2:0], sync_din}.
- On rise_clk with SHIFT_DIRECTION = 0: sreg <= {sync_din, sreg[WIDTH-1:1]}.
- On rise_clk, bit_cnt increments and saturates at 2^CNT_WIDTH-1.
- sr_dout = sreg[WIDTH-1] when SHIFT_DIRECTION = 1, sreg[0] when 0. It is registered and changes only in the cycle after a shift or preset.
- frame_err is set in LATCH if bit_cnt != WIDTH. It is cleared only by reset.
- Simultaneous rise_clk and rise_load: the shift is applied first, then LATCH captures the shifted value, and bit_cnt counts that edge.
- preset_en is honoured only in IDLE; it is ignored in SHIFT and LATCH. A preset does not change bit_cnt or shadow.
- The shadow register keeps its contents between frames. The shift register is not cleared by a load, so the next frame shifts out the previous frame's data.
- Reset values:
  - sreg, shadow, sr_dout, bit_cnt = 0
  - load_done, frame_err = 0
  - FSM in IDLE, synchronizers 0
- Reset may be asserted mid-frame. It aborts the frame immediately with no latch and no pulse.

## Timing
- Latency from an sr_clk pin rising edge to the sreg update: SYNC_STAGES+1 clk_in cycles.
- sr_dout updates one cycle after the sreg update.
- sr_load pin rise to load_done pulse: SYNC_STAGES+2 cycles.
- sr_clk high and low phases must each be at least 2 clk_in periods. Narrower pulses may be missed; this is not detected.
- sr_din must be stable from SYNC_STAGES cycles before until 1 cycle after the sr_clk rising edge. The controller samples sr_dout on its own clock; the returned bit is valid at least SYNC_STAGES+2 cycles after each rise.
- load_done is exactly one cycle wide. A load held high triggers only one LATCH.

## Structure
- Shared package: the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, LATCH=2'd2) and the default WIDTH and CNT_WIDTH constants, also used by the controller.
- One sub-module: sync_edge, a parameterized SYNC_STAGES synchronizer with a rising-edge output, instantiated three times.

## Test plan
- Reset, then shift 170 bits with din = {1'b1,169'b1011}, MSB first, then load -> load_done pulses once, shadow equals the pattern, frame_err = 0, bit_cnt returns to 0.
- Second 170-bit frame of all zeros -> sr_dout replays the first frame's pattern bit by bit (1, 0…0, 1, 0, 1, 1); shadow becomes 0.
- Load after 169 edges -> frame_err = 1 and shadow updated; a following correct frame leaves frame_err at 1.
- preset_en with preset_data = 170'h3 in IDLE, then 170 shifts -> sr_dout emits preset_data from the output end first; the same preset_en pulse during SHIFT is ignored.
- sr_clk and sr_load rising in the same clk_in cycle on edge 170 -> shadow includes the 170th bit and frame_err = 0.
- rst_n low after 80 edges -> all outputs are 0 within the same cycle, no load_done; the next full frame latches correctly.

Source files
------------

// File: rtl/sr_responder_pkg.sv
// Shared definitions for the configuration shift-register link (responder and controller).
package sr_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } sr_state_t;

  localparam int unsigned SR_WIDTH     = 170;
  localparam int unsigned SR_CNT_WIDTH = 8;

endpackage

// File: rtl/sr_responder_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with a rising-edge detect on the synced level.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise_c
);

  logic [STAGES-1:0] pipe;
  logic              sync_d;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pipe   <= '0;
      sync_d <= 1'b0;
    end else begin
      pipe   <= {pipe[STAGES-2:0], din};
      sync_d <= pipe[STAGES-1];
    end
  end

  assign sync   = pipe[STAGES-1];
  assign rise_c = pipe[STAGES-1] & ~sync_d;

endmodule

// File: rtl/sr_responder.sv
// Chip-side configuration shift register: oversampled serial link with shadow latch on load.
module sr_responder
  import sr_responder_pkg::*;
#(
  parameter int unsigned WIDTH           = SR_WIDTH,
  parameter int unsigned CNT_WIDTH       = SR_CNT_WIDTH,
  parameter bit          SHIFT_DIRECTION = 1'b1,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 sr_clk,
  input  logic                 sr_din,
  input  logic                 sr_load,
  input  logic                 preset_en,
  input  logic [WIDTH-1:0]     preset_data,
  output logic                 sr_dout,
  output logic [WIDTH-1:0]     shadow,
  output logic                 load_done,
  output logic                 frame_err,
  output logic [CNT_WIDTH-1:0] bit_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(WIDTH);

  sr_state_t            state;
  logic [WIDTH-1:0]     sreg;
  logic [WIDTH-1:0]     shifted_c;
  logic [CNT_WIDTH-1:0] cnt_inc_c;
  logic                 out_bit_c;

  logic sync_din;
  logic rise_clk;
  logic rise_load;
  logic din_rise_unused;
  logic clk_lvl_unused;
  logic load_lvl_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .din    (sr_clk),
    .sync   (clk_lvl_unused),
    .rise_c (rise_clk)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .din    (sr_din),
    .sync   (sync_din),
    .rise_c (din_rise_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .din    (sr_load),
    .sync   (load_lvl_unused),
    .rise_c (rise_load)
  );

  // Next shift value, output-end bit and saturating count increment.
  always_comb begin
    shifted_c = sreg;
    out_bit_c = 1'b0;
    if (SHIFT_DIRECTION) begin
      shifted_c = {sreg[WIDTH-2:0], sync_din};
      out_bit_c = sreg[WIDTH-1];
    end else begin
      shifted_c = {sync_din, sreg[WIDTH-1:1]};
      out_bit_c = sreg[0];
    end
    cnt_inc_c = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + CNT_WIDTH'(1);
  end

  // Frame FSM with shift register, shadow latch and registered status outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      shadow    <= '0;
      sr_dout   <= 1'b0;
      bit_cnt   <= '0;
      load_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      load_done <= 1'b0;
      sr_dout   <= out_bit_c;

      // Preset only while idle; otherwise a synced clock edge shifts in one bit.
      if (preset_en && (state == IDLE)) begin
        sreg <= preset_data;
      end else if (rise_clk) begin
        sreg <= shifted_c;
      end

      case (state)
        IDLE: begin
          if (rise_clk) begin
            bit_cnt <= cnt_inc_c;
          end
          if (rise_load) begin
            state <= LATCH;
          end else if (rise_clk) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise_clk) begin
            bit_cnt <= cnt_inc_c;
          end
          if (rise_load) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          shadow    <= sreg;
          load_done <= 1'b1;
          if (bit_cnt != CNT_FULL) begin
            frame_err <= 1'b1;
          end
          // An edge landing in the latch cycle starts the next frame.
          bit_cnt <= rise_clk ? CNT_WIDTH'(1) : '0;
          state   <= rise_clk ? SHIFT : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_responder.sv
// Self-checking bench for sr_responder: scoreboarded serial readback and load/latch behaviour.
module tb_sr_responder;

  localparam int W  = 170;
  localparam int CW = 8;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          sr_clk = 1'b0;
  logic          sr_din = 1'b0;
  logic          sr_load = 1'b0;
  logic          preset_en = 1'b0;
  logic [W-1:0]  preset_data = '0;
  logic          sr_dout;
  logic [W-1:0]  shadow;
  logic          load_done;
  logic          frame_err;
  logic [CW-1:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_sreg = '0;
  logic [W-1:0] model_shadow = '0;
  int           model_cnt = 0;
  logic         model_err = 1'b0;
  logic         exp_q[$];

  sr_responder #(
    .WIDTH(W), .CNT_WIDTH(CW), .SHIFT_DIRECTION(1'b1), .SYNC_STAGES(2)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .sr_clk      (sr_clk),
    .sr_din      (sr_din),
    .sr_load     (sr_load),
    .preset_en   (preset_en),
    .preset_data (preset_data),
    .sr_dout     (sr_dout),
    .shadow      (shadow),
    .load_done   (load_done),
    .frame_err   (frame_err),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Waits for the load pulse, checks its latency and width, then the latched state.
  task automatic wait_load_done();
    int lat;
    bit extra;
    lat = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk_in);
      if (load_done === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL load_latency got %0d exp 4", lat);
    end
    extra = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      if (load_done !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL load_done_width extra pulse got 1 exp 0");
    end
    model_err    = model_err | (model_cnt != W);
    model_shadow = model_sreg;
    model_cnt    = 0;
    checks++;
    if (shadow !== model_shadow) begin
      errors++;
      $display("FAIL shadow got %h exp %h", shadow, model_shadow);
    end
    checks++;
    if (frame_err !== model_err) begin
      errors++;
      $display("FAIL frame_err got %b exp %b", frame_err, model_err);
    end
    checks++;
    if (bit_cnt !== CW'(model_cnt)) begin
      errors++;
      $display("FAIL bit_cnt_after_load got %0d exp %0d", bit_cnt, model_cnt);
    end
  endtask

  // One serial bit: push the expected returned bit at the rise, pop it once it must be valid.
  task automatic shift_bit(input logic b, input bit with_load);
    logic exp_bit;
    @(negedge clk_in);
    sr_din = b;
    repeat (2) @(negedge clk_in);
    sr_clk = 1'b1;
    if (with_load) sr_load = 1'b1;
    model_sreg = {model_sreg[W-2:0], b};
    if (model_cnt < 255) model_cnt++;
    exp_q.push_back(model_sreg[W-1]);
    if (with_load) wait_load_done();
    else repeat (4) @(negedge clk_in);
    exp_bit = exp_q.pop_front();
    checks++;
    if (sr_dout !== exp_bit) begin
      errors++;
      $display("FAIL sr_dout got %b exp %b at cnt %0d", sr_dout, exp_bit, model_cnt);
    end
    sr_clk = 1'b0;
    if (with_load) sr_load = 1'b0;
  endtask

  // Shifts the top n bits of data, MSB first, then checks the edge count.
  task automatic shift_frame(input logic [W-1:0] data, input int n);
    for (int i = 0; i < n; i++) shift_bit(data[W-1-i], 1'b0);
    checks++;
    if (bit_cnt !== CW'(model_cnt)) begin
      errors++;
      $display("FAIL bit_cnt got %0d exp %0d", bit_cnt, model_cnt);
    end
  endtask

  task automatic do_load();
    @(negedge clk_in);
    sr_load = 1'b1;
    wait_load_done();
    sr_load = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    checks++;
    if (sr_dout !== 1'b0 || shadow !== '0 || load_done !== 1'b0 ||
        frame_err !== 1'b0 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL %s outputs got dout=%b shadow=%h ld=%b err=%b cnt=%0d exp all 0",
               tag, sr_dout, shadow, load_done, frame_err, bit_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    check_all_zero("reset_released");
  endtask

  task automatic test_pattern_frame();
    logic [W-1:0] pat;
    pat = {1'b1, 169'b1011};
    shift_frame(pat, W);
    do_load();
    checks++;
    if (shadow !== pat || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL pattern_frame shadow=%h err=%b exp %h err 0", shadow, frame_err, pat);
    end
  endtask

  task automatic test_replay();
    checks++;
    if (sr_dout !== 1'b1) begin
      errors++;
      $display("FAIL replay_first_bit got %b exp 1", sr_dout);
    end
    shift_frame('0, W);
    do_load();
    checks++;
    if (shadow !== '0) begin
      errors++;
      $display("FAIL replay_shadow got %h exp 0", shadow);
    end
  endtask

  task automatic test_short_frame();
    shift_frame(rand_vec(), W - 1);
    do_load();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL short_frame_err got %b exp 1", frame_err);
    end
    shift_frame(rand_vec(), W);
    do_load();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL sticky_err got %b exp 1", frame_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    shift_frame(rand_vec(), 80);
    @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (3) begin
      @(negedge clk_in);
      checks++;
      if (load_done !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_load_done got %b exp 0", load_done);
      end
    end
    rst_n = 1'b1;
    model_sreg   = '0;
    model_shadow = '0;
    model_cnt    = 0;
    model_err    = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk_in);
    shift_frame(rand_vec(), W);
    do_load();
    checks++;
    if (frame_err !== 1'b0 || shadow !== model_shadow) begin
      errors++;
      $display("FAIL post_reset_frame err=%b shadow=%h exp err 0 shadow %h",
               frame_err, shadow, model_shadow);
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] d;
    d = rand_vec();
    shift_frame(d, W - 1);
    shift_bit(d[0], 1'b1);
    repeat (3) @(negedge clk_in);
    checks++;
    if (shadow !== d || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous shadow=%h err=%b exp %h err 0", shadow, frame_err, d);
    end
  endtask

  task automatic test_preset();
    @(negedge clk_in);
    preset_data = W'(3);
    preset_en   = 1'b1;
    @(negedge clk_in);
    preset_en   = 1'b0;
    model_sreg  = W'(3);
    repeat (2) @(negedge clk_in);
    checks++;
    if (bit_cnt !== '0 || shadow !== model_shadow || sr_dout !== 1'b0) begin
      errors++;
      $display("FAIL preset_side_effects cnt=%0d dout=%b shadow=%h exp cnt 0 dout 0 shadow %h",
               bit_cnt, sr_dout, shadow, model_shadow);
    end
    shift_frame('0, 85);
    @(negedge clk_in);
    preset_data = '1;
    preset_en   = 1'b1;
    @(negedge clk_in);
    preset_en   = 1'b0;
    shift_frame('0, 85);
    do_load();
  endtask

  initial begin
    test_reset();
    test_pattern_frame();
    test_replay();
    test_short_frame();
    test_reset_mid_frame();
    test_simultaneous();
    test_preset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
